// File: rtl/matrix_load_compare_pkg.sv
// Shared types and width helpers for the run-time loaded matrix compare block.
package matrix_load_compare_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width: at least one bit even for a single row or column.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/matrix_load_compare_if.sv
// Load and expected-vector valid/ready streams feeding matrix_load_compare.
interface matrix_load_compare_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              cmp_valid;
  logic              cmp_ready;
  logic [DATA_W-1:0] cmp_data;

  modport master (
    output wr_valid, wr_data, cmp_valid, cmp_data,
    input  wr_ready, cmp_ready
  );

  modport slave (
    input  wr_valid, wr_data, cmp_valid, cmp_data,
    output wr_ready, cmp_ready
  );
endinterface

// File: rtl/matrix_load_compare_index_ctr.sv
// Row-major row/col walker shared by the load and compare phases.
module matrix_index_ctr
  import matrix_load_compare_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  output logic [idx_w(ROWS)-1:0]   row,
  output logic [idx_w(COLS)-1:0]   col,
  output logic                     last
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Column advances first; wrapping the last element returns to (0,0).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q == ROW_MAX) begin
          row_d = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);
endmodule

// File: rtl/matrix_load_compare.sv
// Loads a ROWS x COLS matrix over a stream, then checks it against an expected stream,
// reporting mismatch count, first mismatch location and pass/fail.
module matrix_load_compare
  import matrix_load_compare_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clear,
  input  logic                                    recompare,
  matrix_load_compare_if.slave                    bus,
  output logic [0:ROWS-1][0:COLS-1][DATA_W-1:0]   output_mat,
  output logic                                    mat_valid,
  output logic [cnt_w(ROWS*COLS)-1:0]             err_cnt,
  output logic [idx_w(ROWS)-1:0]                  first_err_row,
  output logic [idx_w(COLS)-1:0]                  first_err_col,
  output logic                                    done,
  output logic                                    pass
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam int EW = cnt_w(ROWS * COLS);
  localparam logic [EW-1:0] ERR_MAX = EW'(ROWS * COLS);

  typedef logic [0:ROWS-1][0:COLS-1][DATA_W-1:0] mat_t;

  state_e        state_q, state_d;
  mat_t          mat_q, mat_d;
  logic          mat_valid_q, mat_valid_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d, err_cnt_nx;
  logic [RW-1:0] fer_q, fer_d;
  logic [CW-1:0] fec_q, fec_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [RW-1:0] idx_row;
  logic [CW-1:0] idx_col;
  logic          idx_last;
  logic          wr_fire, cmp_fire, mismatch;

  // Readies decode registered state only; clear discards any same-cycle handshake.
  assign bus.wr_ready  = (state_q == LOAD);
  assign bus.cmp_ready = (state_q == CMP);
  assign wr_fire  = bus.wr_valid  && (state_q == LOAD) && !clear;
  assign cmp_fire = bus.cmp_valid && (state_q == CMP)  && !clear;
  assign mismatch = cmp_fire && (bus.cmp_data != mat_q[idx_row][idx_col]);

  matrix_index_ctr #(.ROWS(ROWS), .COLS(COLS)) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear || ((state_q == DONE) && recompare)),
    .inc   (wr_fire || cmp_fire),
    .row   (idx_row),
    .col   (idx_col),
    .last  (idx_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    state_d = (wr_fire && idx_last)  ? CMP  : LOAD;
        CMP:     state_d = (cmp_fire && idx_last) ? DONE : CMP;
        DONE:    state_d = recompare ? CMP : DONE;
        default: state_d = LOAD;
      endcase
    end
  end

  // Saturating error count including the element accepted this cycle.
  always_comb begin
    if (mismatch && (err_cnt_q != ERR_MAX)) begin
      err_cnt_nx = err_cnt_q + 1'b1;
    end else begin
      err_cnt_nx = err_cnt_q;
    end
  end

  // Output/datapath next values.
  always_comb begin
    mat_d       = mat_q;
    mat_valid_d = mat_valid_q;
    err_cnt_d   = err_cnt_q;
    fer_d       = fer_q;
    fec_d       = fec_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    if (clear) begin
      mat_valid_d = 1'b0;
      err_cnt_d   = '0;
      fer_d       = '0;
      fec_d       = '0;
      pass_d      = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (wr_fire) begin
            mat_d[idx_row][idx_col] = bus.wr_data;
            if (idx_last) begin
              mat_valid_d = 1'b1;
              err_cnt_d   = '0;
              fer_d       = '0;
              fec_d       = '0;
            end else begin
              mat_valid_d = mat_valid_q;
            end
          end else begin
            mat_d = mat_q;
          end
        end
        CMP: begin
          err_cnt_d = err_cnt_nx;
          if (mismatch && (err_cnt_q == '0)) begin
            fer_d = idx_row;
            fec_d = idx_col;
          end else begin
            fer_d = fer_q;
            fec_d = fec_q;
          end
          if (cmp_fire && idx_last) begin
            done_d = 1'b1;
            pass_d = (err_cnt_nx == '0);
          end else begin
            done_d = 1'b0;
          end
        end
        DONE: begin
          if (recompare) begin
            err_cnt_d = '0;
            fer_d     = '0;
            fec_d     = '0;
            pass_d    = 1'b0;
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end
        default: begin
          mat_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mat_q       <= '0;
      mat_valid_q <= 1'b0;
      err_cnt_q   <= '0;
      fer_q       <= '0;
      fec_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      mat_q       <= mat_d;
      mat_valid_q <= mat_valid_d;
      err_cnt_q   <= err_cnt_d;
      fer_q       <= fer_d;
      fec_q       <= fec_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign output_mat    = mat_q;
  assign mat_valid     = mat_valid_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_row = fer_q;
  assign first_err_col = fec_q;
  assign done          = done_q;
  assign pass          = pass_q;
endmodule

// File: tb/tb_matrix_load_compare.sv
// Directed scoreboard bench: a 4x4x8 instance plus a 2x3x16 instance.
module tb_matrix_load_compare;
  typedef logic [15:0] vec_t [16];
  typedef struct { int err; int r; int c; int p; } res_t;

  logic clk = 1'b0;
  logic rst_n, clear, recompare;
  always #5 clk = ~clk;

  matrix_load_compare_if #(.DATA_W(8))  bus ();
  matrix_load_compare_if #(.DATA_W(16)) bus2 ();

  logic [0:3][0:3][7:0]  output_mat;
  logic                  mat_valid, done, pass;
  logic [4:0]            err_cnt;
  logic [1:0]            fer, fec;

  logic [0:1][0:2][15:0] output_mat2;
  logic                  mat_valid2, done2, pass2;
  logic [2:0]            err_cnt2;
  logic [0:0]            fer2;
  logic [1:0]            fec2;

  matrix_load_compare #(.ROWS(4), .COLS(4), .DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .recompare(recompare), .bus(bus),
    .output_mat(output_mat), .mat_valid(mat_valid), .err_cnt(err_cnt),
    .first_err_row(fer), .first_err_col(fec), .done(done), .pass(pass)
  );

  matrix_load_compare #(.ROWS(2), .COLS(3), .DATA_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .recompare(recompare), .bus(bus2),
    .output_mat(output_mat2), .mat_valid(mat_valid2), .err_cnt(err_cnt2),
    .first_err_row(fer2), .first_err_col(fec2), .done(done2), .pass(pass2)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  res_t sb_q[$];
  vec_t ref_mat, ref2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input vec_t m, input vec_t v, input int n, input int cols);
    res_t r = '{0, 0, 0, 0};
    for (int i = 0; i < n; i++) begin
      if (m[i] !== v[i]) begin
        if (r.err == 0) begin
          r.r = i / cols;
          r.c = i % cols;
        end
        r.err++;
      end
    end
    r.p = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic send_wr(input logic [7:0] d, input int gap);
    int n = 0;
    repeat ($urandom_range(gap, 0)) begin
      check("rdy_idle_load", {bus.wr_ready, bus.cmp_ready}, 2'b10);
      step();
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    while (!bus.wr_ready && n < 50) begin step(); n++; end
    check("wr_bound", (n < 50), 1'b1);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic send_cmp(input logic [7:0] d, input int gap);
    int n = 0;
    repeat ($urandom_range(gap, 0)) begin
      check("rdy_idle_cmp", {bus.wr_ready, bus.cmp_ready}, 2'b01);
      step();
    end
    bus.cmp_valid = 1'b1;
    bus.cmp_data  = d;
    while (!bus.cmp_ready && n < 50) begin step(); n++; end
    check("cmp_bound", (n < 50), 1'b1);
    step();
    bus.cmp_valid = 1'b0;
  endtask

  task automatic load1(input vec_t v, input int gap);
    for (int i = 0; i < 16; i++) begin
      send_wr(v[i][7:0], gap);
      ref_mat[i] = v[i];
    end
  endtask

  task automatic check_mat1(input string tag);
    for (int i = 0; i < 16; i++) check(tag, output_mat[i / 4][i % 4], ref_mat[i]);
  endtask

  // Full compare pass; expectation enters the scoreboard as the last beat is driven.
  task automatic compare1(input vec_t v, input int gap);
    res_t e;
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) sb_q.push_back(model(ref_mat, v, 16, 4));
      send_cmp(v[i][7:0], gap);
    end
    while (!done && n < 5) begin step(); n++; end
    check("done_latency", n, 0);
    e = sb_q.pop_front();
    check("err_cnt", err_cnt, e.err);
    check("first_err_row", fer, e.r);
    check("first_err_col", fec, e.c);
    check("pass", pass, e.p);
    step();
    check("done_pulse", done, 1'b0);
    check("rdy_done", {bus.wr_ready, bus.cmp_ready}, 2'b00);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  vec_t t1 = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd1,
               16'd2, 16'd1, 16'd2, 16'd1, 16'd1, 16'd2, 16'd3, 16'd1};
  vec_t t2;
  vec_t t6 = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA,
               16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  vec_t t6c;

  initial begin
    res_t e2;
    int n;
    t2 = t1;
    t2[6]  = 16'd4;
    t2[15] = 16'd0;
    t6c = t6;
    t6c[5] = 16'h0000;

    rst_n = 1'b0; clear = 1'b0; recompare = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.cmp_valid = 1'b0; bus.cmp_data = '0;
    bus2.wr_valid = 1'b0; bus2.wr_data = '0; bus2.cmp_valid = 1'b0; bus2.cmp_data = '0;
    step(); step();

    check("rst_mat", (output_mat === 128'd0), 1'b1);
    check("rst_flags", {mat_valid, done, pass, err_cnt, fer, fec}, 12'd0);
    check("rst_rdy", {bus.wr_ready, bus.cmp_ready}, 2'b10);
    check("rst2_flags", {mat_valid2, done2, pass2, err_cnt2, fer2, fec2}, 9'd0);
    rst_n = 1'b1;

    // Test 1: load then matching compare
    load1(t1, 0);
    check("t1_mat_valid", mat_valid, 1'b1);
    check("t1_rdy_cmp", {bus.wr_ready, bus.cmp_ready}, 2'b01);
    check("t1_mat12", output_mat[1][2], 8'd3);
    check_mat1("t1_mat");
    compare1(t1, 0);

    // Test 2: two corrupted expected elements
    pulse_clear();
    check("clr_flags", {mat_valid, pass, err_cnt, fer, fec}, 11'd0);
    check("clr_rdy", {bus.wr_ready, bus.cmp_ready}, 2'b10);
    load1(t1, 0);
    compare1(t2, 0);

    // Test 5: recompare from DONE; load traffic during CMP must be ignored
    recompare = 1'b1;
    step();
    recompare = 1'b0;
    check("rcmp_cleared", {pass, err_cnt, fer, fec}, 10'd0);
    check("rcmp_rdy", {bus.wr_ready, bus.cmp_ready}, 2'b01);
    check("rcmp_mat_valid", mat_valid, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hAA;
    compare1(t1, 0);
    bus.wr_valid = 1'b0;
    check_mat1("t5_mat_kept");

    // Test 3: random gaps on both streams
    pulse_clear();
    load1(t1, 2);
    check_mat1("t3_mat");
    compare1(t1, 2);

    // Test 4: clear mid-load with a same-cycle handshake, then full reload
    pulse_clear();
    for (int i = 0; i < 5; i++) send_wr(t1[i][7:0], 0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    pulse_clear();
    bus.wr_valid = 1'b0;
    check("t4_mat_valid", mat_valid, 1'b0);
    check("t4_rdy", {bus.wr_ready, bus.cmp_ready}, 2'b10);
    load1(t1, 0);
    check_mat1("t4_mat");
    compare1(t1, 0);

    // Reset in the middle of a compare pass
    pulse_clear();
    load1(t1, 0);
    for (int i = 0; i < 7; i++) send_cmp(t2[i][7:0], 0);
    check("pre_rst_err", err_cnt, 5'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_mat", (output_mat === 128'd0), 1'b1);
    check("mid_rst_flags", {mat_valid, done, pass, err_cnt, fer, fec}, 12'd0);
    check("mid_rst_rdy", {bus.wr_ready, bus.cmp_ready}, 2'b10);
    rst_n = 1'b1;

    // Test 6: 2x3x16 instance, last element mismatching
    for (int i = 0; i < 6; i++) begin
      n = 0;
      bus2.wr_valid = 1'b1;
      bus2.wr_data  = t6[i];
      while (!bus2.wr_ready && n < 50) begin step(); n++; end
      step();
      ref2[i] = t6[i];
    end
    bus2.wr_valid = 1'b0;
    check("t6_mat_valid", mat_valid2, 1'b1);
    for (int i = 0; i < 6; i++) check("t6_mat", output_mat2[i / 3][i % 3], ref2[i]);
    for (int i = 0; i < 6; i++) begin
      n = 0;
      if (i == 5) sb_q.push_back(model(ref2, t6c, 6, 3));
      bus2.cmp_valid = 1'b1;
      bus2.cmp_data  = t6c[i];
      while (!bus2.cmp_ready && n < 50) begin step(); n++; end
      step();
    end
    bus2.cmp_valid = 1'b0;
    n = 0;
    while (!done2 && n < 5) begin step(); n++; end
    check("t6_done_latency", n, 0);
    e2 = sb_q.pop_front();
    check("t6_err_cnt", err_cnt2, e2.err);
    check("t6_first_err_row", fer2, e2.r);
    check("t6_first_err_col", fec2, e2.c);
    check("t6_pass", pass2, e2.p);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
